// File: rtl/fetch_stage_prefetch_if.sv
// Bus between the fetch stage and its surroundings (loader, decode, debug).
// The master side drives the controls and the load port; the slave side is the fetch stage.
interface fetch_stage_prefetch_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_ADDR     = 8,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic                   i_valid;
    logic                   i_stall;
    logic                   i_pc_src;
    logic [NB_DATA-1:0]     i_pc_next;
    logic                   i_load_en;
    logic [NB_ADDR-1:0]     i_load_addr;
    logic [NB_DATA-1:0]     i_load_data;
    logic [NB_DATA-1:0]     o_instruction;
    logic [NB_DATA-1:0]     o_pc_next;
    logic [NB_REGISTER-1:0] o_rs;
    logic [NB_REGISTER-1:0] o_rt;
    logic                   o_inst_valid;
    logic                   o_halted;
    logic [CNT_W-1:0]       o_queue_count;

    modport master (
        output i_valid, i_stall, i_pc_src, i_pc_next, i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_pc_next, o_rs, o_rt, o_inst_valid, o_halted, o_queue_count
    );

    modport slave (
        input  i_valid, i_stall, i_pc_src, i_pc_next, i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_pc_next, o_rs, o_rt, o_inst_valid, o_halted, o_queue_count
    );
endinterface

// File: rtl/fetch_stage_prefetch.sv
// MIPS fetch stage with loadable instruction memory and a prefetch queue that
// keeps fetching while decode stalls; supports redirect/flush and sticky halt.
module fetch_stage_prefetch #(
    parameter int                  NB_DATA     = 32,
    parameter int                  NB_REGISTER = 5,
    parameter int                  NB_ADDR     = 8,
    parameter int                  QUEUE_DEPTH = 4,
    parameter int                  PC_STEP     = 1,
    parameter logic [NB_DATA-1:0]  HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    fetch_stage_prefetch_if.slave   bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int MEM_WORDS = 1 << NB_ADDR;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [NB_DATA-1:0] mem_r      [MEM_WORDS];
    logic [NB_DATA-1:0] inst_q_r   [QUEUE_DEPTH];
    logic [NB_DATA-1:0] pc_q_r     [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [NB_DATA-1:0] fetch_pc_r;
    logic               halted_r;

    logic               inst_valid_s;
    logic               redirect_s;
    logic               pop_s;
    logic               push_s;
    logic [NB_DATA-1:0] fetch_word_s;
    logic [NB_DATA-1:0] next_fetch_pc_s;
    logic [NB_DATA-1:0] head_inst_s;
    logic [NB_DATA-1:0] head_pc_s;

    // Handshake decode: redirect overrides both push and pop.
    always_comb begin
        inst_valid_s    = (count_r != {CNT_W{1'b0}});
        redirect_s      = bus.i_valid && bus.i_pc_src;
        pop_s           = inst_valid_s && bus.i_valid && !bus.i_stall && !bus.i_pc_src;
        push_s          = bus.i_valid && !bus.i_pc_src && !bus.i_load_en && !halted_r &&
                          ((count_r < DEPTH_C) || pop_s);
        fetch_word_s    = mem_r[fetch_pc_r[NB_ADDR-1:0]];
        next_fetch_pc_s = fetch_pc_r + NB_DATA'(PC_STEP);
    end

    // Head-of-queue view; an empty queue presents all zeros.
    always_comb begin
        if (inst_valid_s) begin
            head_inst_s = inst_q_r[rd_ptr_r];
            head_pc_s   = pc_q_r[rd_ptr_r];
        end else begin
            head_inst_s = {NB_DATA{1'b0}};
            head_pc_s   = {NB_DATA{1'b0}};
        end
    end

    assign bus.o_instruction = head_inst_s;
    assign bus.o_pc_next     = head_pc_s;
    assign bus.o_rs          = head_inst_s[21 +: NB_REGISTER];
    assign bus.o_rt          = head_inst_s[16 +: NB_REGISTER];
    assign bus.o_inst_valid  = inst_valid_s;
    assign bus.o_halted      = halted_r;
    assign bus.o_queue_count = count_r;

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (bus.i_load_en) begin
            mem_r[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // Queue entry storage; only pointers and count need reset.
    always_ff @(posedge i_clock) begin
        if (push_s) begin
            inst_q_r[wr_ptr_r] <= fetch_word_s;
            pc_q_r[wr_ptr_r]   <= next_fetch_pc_s;
        end
    end

    // Fetch PC, queue pointers/count and sticky halt flag.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            fetch_pc_r <= {NB_DATA{1'b0}};
            halted_r   <= 1'b0;
        end else if (redirect_s) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            fetch_pc_r <= bus.i_pc_next;
            halted_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                fetch_pc_r <= next_fetch_pc_s;
                if (fetch_word_s == HALT_WORD) begin
                    halted_r <= 1'b1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage_prefetch.sv
// Directed bench for fetch_stage_prefetch: streaming, stall fill/drain,
// redirect flush, halt, memory load and asynchronous reset.
module tb_fetch_stage_prefetch;
    logic i_clock;
    logic i_reset;
    int   total;
    int   bad;

    fetch_stage_prefetch_if #(.NB_DATA(32), .NB_REGISTER(5), .NB_ADDR(8), .QUEUE_DEPTH(4)) bus ();

    fetch_stage_prefetch #(
        .NB_DATA(32), .NB_REGISTER(5), .NB_ADDR(8), .QUEUE_DEPTH(4),
        .PC_STEP(1), .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = addr;
        bus.i_load_data = data;
        step();
        bus.i_load_en   = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_valid  = 1'b0;
        bus.i_stall  = 1'b0;
        bus.i_pc_src = 1'b0;
        i_reset = 1'b0;
        #2;
        i_reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_reset         = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_pc_src    = 1'b0;
        bus.i_pc_next   = 32'h0;
        bus.i_load_en   = 1'b0;
        bus.i_load_addr = 8'h0;
        bus.i_load_data = 32'h0;
        #12;
        i_reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) load(8'(i), 32'h100 + 32'(i));
        load(8'h20, 32'hABCD_0000);

        chk("rst_count", 32'(bus.o_queue_count), 32'd0);
        chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("rst_halted", 32'(bus.o_halted), 32'd0);
        chk("rst_inst", bus.o_instruction, 32'h0);
        chk("rst_pc", bus.o_pc_next, 32'h0);

        // Free-running stream
        bus.i_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("run_pc", bus.o_pc_next, 32'(k));
            chk("run_inst", bus.o_instruction, 32'h100 + 32'(k - 1));
            chk("run_count", 32'(bus.o_queue_count), 32'd1);
        end

        // Stall fill then drain
        do_reset();
        bus.i_valid = 1'b1;
        bus.i_stall = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("stall_count", 32'(bus.o_queue_count), (k < 4) ? 32'(k) : 32'd4);
            chk("stall_pc", bus.o_pc_next, 32'd1);
        end
        bus.i_stall = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("drain_pc", bus.o_pc_next, 32'(k));
            chk("drain_count", 32'(bus.o_queue_count), 32'd4);
        end

        // Redirect flush with 3 queued entries
        do_reset();
        bus.i_valid = 1'b1;
        bus.i_stall = 1'b1;
        step(); step(); step();
        chk("pre_redir_count", 32'(bus.o_queue_count), 32'd3);
        bus.i_pc_src  = 1'b1;
        bus.i_pc_next = 32'h20;
        step();
        chk("redir_count", 32'(bus.o_queue_count), 32'd0);
        chk("redir_valid", 32'(bus.o_inst_valid), 32'd0);
        bus.i_pc_src = 1'b0;
        step();
        chk("redir_inst", bus.o_instruction, 32'hABCD_0000);
        chk("redir_pc", bus.o_pc_next, 32'h21);
        chk("redir_rs", 32'(bus.o_rs), 32'h1E);
        chk("redir_rt", 32'(bus.o_rt), 32'h0D);

        // Halt at pc 3
        bus.i_valid = 1'b0;
        bus.i_stall = 1'b0;
        load(8'h3, 32'hFFFF_FFFF);
        do_reset();
        bus.i_valid = 1'b1;
        step(); step(); step();
        chk("pre_halt_flag", 32'(bus.o_halted), 32'd0);
        step();
        chk("halt_flag", 32'(bus.o_halted), 32'd1);
        chk("halt_pc", bus.o_pc_next, 32'd4);
        chk("halt_inst", bus.o_instruction, 32'hFFFF_FFFF);
        step();
        chk("halt_drain", 32'(bus.o_queue_count), 32'd0);
        step();
        chk("halt_no_pc5", 32'(bus.o_queue_count), 32'd0);
        chk("halt_sticky", 32'(bus.o_halted), 32'd1);
        bus.i_pc_src  = 1'b1;
        bus.i_pc_next = 32'h0;
        step();
        chk("unhalt_flag", 32'(bus.o_halted), 32'd0);
        bus.i_pc_src = 1'b0;
        step();
        chk("resume_pc", bus.o_pc_next, 32'd1);
        chk("resume_inst", bus.o_instruction, 32'h100);

        // Load program with fetch frozen
        do_reset();
        load(8'h0, 32'h11);
        load(8'h1, 32'h22);
        load(8'h2, 32'h33);
        load(8'h3, 32'h44);
        chk("load_frozen_count", 32'(bus.o_queue_count), 32'd0);
        bus.i_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("load_inst", bus.o_instruction, 32'h11 * 32'(k));
            chk("load_pc", bus.o_pc_next, 32'(k));
        end

        // Asynchronous reset while full and stalled
        do_reset();
        bus.i_valid = 1'b1;
        bus.i_stall = 1'b1;
        step(); step(); step(); step();
        chk("full_count", 32'(bus.o_queue_count), 32'd4);
        #3;
        i_reset = 1'b0;
        #1;
        chk("async_count", 32'(bus.o_queue_count), 32'd0);
        chk("async_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("async_inst", bus.o_instruction, 32'h0);
        chk("async_pc", bus.o_pc_next, 32'h0);
        i_reset = 1'b1;
        bus.i_stall = 1'b0;
        step();
        chk("restart_pc", bus.o_pc_next, 32'd1);
        chk("restart_inst", bus.o_instruction, 32'h11);

        // Load blocks push while pops continue; i_valid=0 holds state
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = 8'h40;
        bus.i_load_data = 32'h55;
        step();
        bus.i_load_en = 1'b0;
        chk("load_block_count", 32'(bus.o_queue_count), 32'd0);
        step();
        chk("after_load_pc", bus.o_pc_next, 32'd2);
        chk("after_load_inst", bus.o_instruction, 32'h22);
        bus.i_valid = 1'b0;
        step();
        chk("hold_pc", bus.o_pc_next, 32'd2);
        chk("hold_count", 32'(bus.o_queue_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage_prefetch.md
Name: fetch_stage_prefetch

Overview:
Parametrised successor to the MIPS pipeline fetch stage. Holds a loadable word-addressed instruction memory, a PC register and a small prefetch queue, so fetch keeps running while decode stalls. Supports branch/jump redirect with queue flush, and halt detection for the debug unit. Sits between the debug/UART loader and the decode stage.

Parameters:
NB_DATA, 32, instruction and PC width
NB_REGISTER, 5, register-index width of o_rs/o_rt
NB_ADDR, 8, instruction memory address width (2^NB_ADDR words)
QUEUE_DEPTH, 4, prefetch queue entries (power of 2, >=2)
PC_STEP, 1, PC increment per fetched word
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
i_clock  in  1  single clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  global run/step enable; 0 freezes fetch, pop and redirect
i_stall  in  1  decode cannot accept the head instruction this cycle
i_pc_src  in  1  redirect request (taken branch/jump)
i_pc_next  in  NB_DATA  redirect target PC
i_load_en  in  1  instruction memory write strobe
i_load_addr  in  NB_ADDR  write word address
i_load_data  in  NB_DATA  write data
o_instruction  out  NB_DATA  head instruction
o_pc_next  out  NB_DATA  PC of head instruction + PC_STEP
o_rs  out  NB_REGISTER  o_instruction[25:21]
o_rt  out  NB_REGISTER  o_instruction[20:16]
o_inst_valid  out  1  queue non-empty
o_halted  out  1  HALT_WORD fetched; fetch stopped (sticky)
o_queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries

Behaviour:
- Reset (i_reset=0, asynchronous): fetch PC=0, queue empty, o_queue_count=0, o_inst_valid=0, o_halted=0. Memory contents are not cleared. Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Outputs are taken combinationally from the queue head. When the queue is empty, o_instruction, o_pc_next, o_rs and o_rt are 0.
- Pop: on an edge with o_inst_valid && i_valid && !i_stall && !i_pc_src.
- Push: on an edge with i_valid && !i_pc_src && !i_load_en && !o_halted && (count<QUEUE_DEPTH or a pop occurs that edge).
  - Entry written is {mem[fetch_pc[NB_ADDR-1:0]], fetch_pc+PC_STEP}.
  - Memory read is combinational.
  - fetch_pc advances by PC_STEP. Address bits wrap modulo 2^NB_ADDR; the full NB_DATA PC wraps modulo 2^NB_DATA.
- Push and pop on the same edge: count unchanged. This is legal when the queue is full.
- Latency:
  - First push happens on the first edge with i_valid=1 after reset release; o_inst_valid is high after that edge.
  - With no stall, o_pc_next increments by PC_STEP every cycle (1, 2, 3, ...).
- Redirect (i_pc_src && i_valid):
  - Has priority over push and pop.
  - At the edge: queue flushed (count=0), fetch_pc<=i_pc_next, o_halted<=0.
  - Next eligible edge pushes mem[target].
  - i_pc_src is ignored when i_valid=0.
- Halt:
  - A fetched word equal to HALT_WORD is pushed normally, and o_halted is set at the same edge.
  - No further pushes until redirect or reset.
  - The queue still drains through pops.
- Load:
  - i_load_en writes mem[i_load_addr] at the edge, independent of i_valid.
  - While i_load_en=1, push is blocked (no read/write hazard); pops continue.
- i_valid=0: no push, no pop, no redirect; all state holds except memory writes.
- Stall with queue full: push is blocked and fetch_pc holds.

Test Plan:
- Mem[i]=i+0x100 for i=0..15, reset, i_valid=1 for 10 cycles, no stall -> o_pc_next=1..10 on consecutive edges; o_instruction=0x100..0x109; o_queue_count stays 1.
- Same program, i_stall=1 for 8 cycles -> count rises 1,2,3,4 then holds at 4; head stays pc_next=1. Release stall -> heads 1,2,3,4,5 on consecutive cycles with no bubble.
- Queue holding 3 entries, i_pc_src=1 with i_pc_next=0x20 and mem[0x20]=0xABCD0000 -> after edge count=0, o_inst_valid=0; next edge o_instruction=0xABCD0000, o_pc_next=0x21.
- mem[3]=HALT_WORD, free-run -> o_halted=1 after the edge fetching pc 3; count drains to 0; last o_pc_next=4; no pc 5. Redirect to 0 -> o_halted=0 and fetch resumes.
- i_load_en pulses writing mem[0..3]=0x11,0x22,0x33,0x44 with i_valid=0, then i_valid=1 -> instructions 0x11, 0x22, 0x33, 0x44 in order.
- Drop i_reset to 0 between clock edges during a stall with count=4 -> outputs and count are 0 immediately, before the next edge; after release, fetch restarts at pc 0.
